// File: rtl/ahb2_slv_regmem.sv
// AHB2 slave responder over a resettable word-organised register memory,
// with programmable OKAY wait states and two-cycle ERROR responses.
module ahb2_slv_regmem #(
    parameter int unsigned DEPTH_LOG2  = 6,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic [3:0]  hprot,
    input  logic [31:0] hwdata,
    input  logic        hreadyi,
    output logic [31:0] hrdata,
    output logic        hreadyo,
    output logic [1:0]  hresp
);
    localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
    localparam int unsigned AW        = DEPTH_LOG2 + 2;
    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam logic [1:0]  RESP_ERR  = 2'b01;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t                  state;
    logic [3:0]              cnt;
    logic [AW-1:0]           addr_q;
    logic                    hwrite_q;
    logic [1:0]              hsize_q;
    logic [31:0]             mem [DEPTH];

    logic                    accept;
    logic                    can_accept;
    logic                    acc_err;
    logic                    commit_en;
    logic [31:0]             commit_word;
    logic [31:0]             fwd_word;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [DEPTH_LOG2-1:0]   acc_idx;
    logic                    unused_inputs;

    assign unused_inputs = ^{hburst, hprot, htrans[0]};
    assign idx_q   = addr_q[AW-1:2];
    assign acc_idx = haddr[AW-1:2];

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [1:0]  size,
                                                input logic [1:0]  offset);
        logic [3:0]  be;
        logic [31:0] res;
        case (size)
            2'b00:   be = 4'b0001 << offset;
            2'b01:   be = offset[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        for (int unsigned b = 0; b < 4; b++)
            res[8*b +: 8] = be[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        return res;
    endfunction

    always_comb begin
        accept      = hsel & hreadyi & htrans[1];
        can_accept  = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR2);
        acc_err     = (hsize > 3'b010) || ((haddr >> AW) != 32'd0) ||
                      ((hsize == 3'b001) && haddr[0]) ||
                      ((hsize == 3'b010) && (haddr[1:0] != 2'b00));
        commit_en   = (state == ST_DONE) && hwrite_q;
        commit_word = merge_lanes(mem[idx_q], hwdata, hsize_q, addr_q[1:0]);
        // A read accepted on the edge that commits a write to the same word sees the new data.
        fwd_word    = (commit_en && (idx_q == acc_idx)) ? commit_word : mem[acc_idx];
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (commit_en) begin
            mem[idx_q] <= commit_word;
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            addr_q   <= '0;
            hwrite_q <= 1'b0;
            hsize_q  <= '0;
            hreadyo  <= 1'b1;
            hresp    <= RESP_OKAY;
            hrdata   <= '0;
        end else begin
            hrdata <= '0;
            if (can_accept && accept) begin
                addr_q   <= haddr[AW-1:0];
                hwrite_q <= hwrite;
                hsize_q  <= hsize[1:0];
                if (acc_err) begin
                    state   <= ST_ERR1;
                    hreadyo <= 1'b0;
                    hresp   <= RESP_ERR;
                end else if (WAIT_STATES == 0) begin
                    state   <= ST_DONE;
                    hreadyo <= 1'b1;
                    hresp   <= RESP_OKAY;
                    if (!hwrite)
                        hrdata <= fwd_word;
                end else begin
                    state   <= ST_WAIT;
                    cnt     <= WAIT_INIT;
                    hreadyo <= 1'b0;
                    hresp   <= RESP_OKAY;
                end
            end else begin
                case (state)
                    ST_WAIT: begin
                        hresp <= RESP_OKAY;
                        if (cnt == '0) begin
                            state   <= ST_DONE;
                            hreadyo <= 1'b1;
                            if (!hwrite_q)
                                hrdata <= mem[idx_q];
                        end else begin
                            cnt     <= cnt - 4'd1;
                            hreadyo <= 1'b0;
                        end
                    end
                    ST_ERR1: begin
                        state   <= ST_ERR2;
                        hreadyo <= 1'b1;
                        hresp   <= RESP_ERR;
                    end
                    default: begin
                        state   <= ST_IDLE;
                        hreadyo <= 1'b1;
                        hresp   <= RESP_OKAY;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ahb2_slv_regmem.sv
// Bench for ahb2_slv_regmem: two slaves (0 and 3 wait states) behind a simple
// decoder, directed vector tables plus random traffic against a memory model.
module tb_ahb2_slv_regmem;
    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_BUSY = 2'b01;
    localparam logic [1:0] T_NSEQ = 2'b10;
    localparam logic [1:0] T_SEQ  = 2'b11;
    localparam logic [1:0] R_OK   = 2'b00;
    localparam logic [1:0] R_ERR  = 2'b01;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          chk;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } xfer_t;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        hsel_m;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        dsel;
    logic        hsel0, hsel3, hreadyi;
    logic [31:0] hrdata0, hrdata3, rd_m;
    logic        hreadyo0, hreadyo3, rdy_m;
    logic [1:0]  hresp0, hresp3, rsp_m;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] mem_m [2][64];

    always #5 hclk = ~hclk;

    assign hsel0   = hsel_m & ~dsel;
    assign hsel3   = hsel_m & dsel;
    assign hreadyi = dsel ? hreadyo3 : hreadyo0;
    assign rd_m    = dsel ? hrdata3  : hrdata0;
    assign rdy_m   = dsel ? hreadyo3 : hreadyo0;
    assign rsp_m   = dsel ? hresp3   : hresp0;

    ahb2_slv_regmem #(.DEPTH_LOG2(6), .WAIT_STATES(0)) u_dut0 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
        .hreadyi(hreadyi), .hrdata(hrdata0), .hreadyo(hreadyo0), .hresp(hresp0)
    );

    ahb2_slv_regmem #(.DEPTH_LOG2(6), .WAIT_STATES(3)) u_dut3 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel3), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
        .hreadyi(hreadyi), .hrdata(hrdata3), .hreadyo(hreadyo3), .hresp(hresp3)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic xfer_t mk(input logic sel, input logic [1:0] trans, input logic wr,
                                 input logic [2:0] sz, input logic [31:0] addr,
                                 input logic [31:0] wdata, input bit c,
                                 input logic [1:0] er, input logic [31:0] ed);
        xfer_t x;
        x.sel = sel; x.trans = trans; x.wr = wr; x.sz = sz; x.addr = addr;
        x.wdata = wdata; x.chk = c; x.exp_resp = er; x.exp_rdata = ed;
        return x;
    endfunction

    // Reference rules: 256-byte space, naturally aligned sizes of 1/2/4 bytes only.
    function automatic bit m_err(input xfer_t x);
        if (x.sz > 3'd2) return 1'b1;
        if (x.addr >= 32'd256) return 1'b1;
        return (x.addr % (32'd1 << x.sz)) != 32'd0;
    endfunction

    task automatic m_write(input int d, input xfer_t x);
        logic [31:0] w;
        int          lane;
        w = mem_m[d][x.addr[7:2]];
        for (int k = 0; k < (1 << x.sz); k++) begin
            lane = int'(x.addr[1:0]) + k;
            w[8*lane +: 8] = x.wdata[8*lane +: 8];
        end
        mem_m[d][x.addr[7:2]] = w;
    endtask

    task automatic m_clear();
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 64; w++)
                mem_m[d][w] = 32'h0;
    endtask

    // Pipelined master: called and returns at posedge+1 with the bus idle.
    task automatic run_seq(input xfer_t q[$]);
        int          i, c, cyc, ws;
        bit          have_dp, dp_err, rdy_s, exp_rdy;
        xfer_t       dp;
        logic [1:0]  exp_rsp;
        logic [31:0] exp_rd;
        i = 0; c = 0; cyc = 0; have_dp = 0; dp_err = 0;
        ws = dsel ? 3 : 0;
        while (i < q.size() || have_dp) begin
            if (i < q.size()) begin
                hsel_m = q[i].sel; htrans = q[i].trans; haddr = q[i].addr;
                hwrite = q[i].wr;  hsize  = q[i].sz;
            end else begin
                hsel_m = 1'b0; htrans = T_IDLE;
            end
            hburst = 3'($urandom()); hprot = 4'($urandom());
            hwdata = have_dp ? dp.wdata : $urandom();
            @(negedge hclk);
            cyc++;
            if (have_dp) begin
                c++;
                dp_err = m_err(dp);
                if (dp_err) begin
                    exp_rdy = (c >= 2); exp_rsp = R_ERR; exp_rd = 32'h0;
                end else begin
                    exp_rdy = (c >= ws + 1); exp_rsp = R_OK;
                    exp_rd  = (exp_rdy && !dp.wr) ? mem_m[dsel][dp.addr[7:2]] : 32'h0;
                end
            end else begin
                exp_rdy = 1'b1; exp_rsp = R_OK; exp_rd = 32'h0;
            end
            chk("hreadyo", 32'(rdy_m), 32'(exp_rdy));
            chk("hresp",   32'(rsp_m), 32'(exp_rsp));
            chk("hrdata",  rd_m, exp_rd);
            rdy_s = rdy_m;
            if (have_dp && rdy_s && dp.chk) begin
                chk("vec_resp",  32'(rsp_m), 32'(dp.exp_resp));
                chk("vec_rdata", rd_m, dp.exp_rdata);
            end
            if ((have_dp && c > ws + 3) || cyc > 20 * (q.size() + 2)) begin
                n_cmp++; n_err++;
                $display("FAIL timeout: data phase stuck after %0d cycles, expected at most %0d", c, ws + 1);
                break;
            end
            @(posedge hclk); #1;
            if (rdy_s) begin
                if (have_dp && !dp_err && dp.wr) m_write(int'(dsel), dp);
                have_dp = 0;
                if (i < q.size()) begin
                    if (q[i].sel && q[i].trans[1]) begin
                        dp = q[i]; have_dp = 1; c = 0;
                    end
                    i++;
                end
            end
        end
        hsel_m = 1'b0; htrans = T_IDLE;
    endtask

    task automatic rand_run(input int n);
        xfer_t q[$];
        xfer_t x;
        int    r;
        for (int k = 0; k < n; k++) begin
            r = int'($urandom_range(0, 19));
            x = mk(1'b1, T_NSEQ, 1'($urandom_range(0, 1)), 3'd2, 32'h0, $urandom(), 0, R_OK, 32'h0);
            if (r == 0) x.sel = 1'b0;
            if (r == 1) x.trans = T_IDLE;
            if (r == 2) x.trans = T_BUSY;
            if (r == 3) x.trans = T_SEQ;
            x.sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            x.addr = $urandom_range(0, ($urandom_range(0, 1) != 0) ? 63 : 255);
            if ($urandom_range(0, 3) != 0) x.addr = x.addr & ~((32'd1 << x.sz) - 32'd1);
            if ($urandom_range(0, 14) == 0) x.addr = x.addr | (32'($urandom_range(1, 255)) << 8);
            q.push_back(x);
        end
        run_seq(q);
    endtask

    xfer_t vec [17];
    xfer_t q [$];

    initial begin
        vec[0]  = mk(1, T_NSEQ, 1, 3'd2, 32'h10,  32'hDEADBEEF, 1, R_OK,  32'h0);
        vec[1]  = mk(1, T_NSEQ, 0, 3'd2, 32'h10,  32'h0,        1, R_OK,  32'hDEADBEEF);
        vec[2]  = mk(1, T_NSEQ, 1, 3'd2, 32'h0,   32'h11223344, 1, R_OK,  32'h0);
        vec[3]  = mk(1, T_NSEQ, 1, 3'd0, 32'h2,   32'h00AA0000, 1, R_OK,  32'h0);
        vec[4]  = mk(1, T_NSEQ, 1, 3'd1, 32'h0,   32'h0000BEEF, 1, R_OK,  32'h0);
        vec[5]  = mk(1, T_NSEQ, 0, 3'd2, 32'h0,   32'h0,        1, R_OK,  32'h11AABEEF);
        vec[6]  = mk(1, T_NSEQ, 1, 3'd2, 32'h102, 32'hFFFFFFFF, 1, R_ERR, 32'h0);
        vec[7]  = mk(1, T_NSEQ, 1, 3'd3, 32'h8,   32'hFFFFFFFF, 1, R_ERR, 32'h0);
        vec[8]  = mk(1, T_NSEQ, 1, 3'd2, 32'h100, 32'hFFFFFFFF, 1, R_ERR, 32'h0);
        vec[9]  = mk(1, T_NSEQ, 0, 3'd2, 32'h0,   32'h0,        1, R_OK,  32'h11AABEEF);
        vec[10] = mk(1, T_IDLE, 1, 3'd2, 32'h0,   32'h0,        0, R_OK,  32'h0);
        vec[11] = mk(1, T_BUSY, 1, 3'd2, 32'h0,   32'h0,        0, R_OK,  32'h0);
        vec[12] = mk(0, T_NSEQ, 1, 3'd2, 32'h0,   32'h0,        0, R_OK,  32'h0);
        vec[13] = mk(1, T_SEQ,  0, 3'd1, 32'h2,   32'h0,        1, R_OK,  32'h11AABEEF);
        vec[14] = mk(1, T_NSEQ, 1, 3'd1, 32'h1,   32'hFFFFFFFF, 1, R_ERR, 32'h0);
        vec[15] = mk(1, T_NSEQ, 1, 3'd2, 32'hFC,  32'hCAFEF00D, 1, R_OK,  32'h0);
        vec[16] = mk(1, T_NSEQ, 0, 3'd0, 32'hFF,  32'h0,        1, R_OK,  32'hCAFEF00D);

        m_clear();
        dsel = 1'b0; hreset = 1'b1; hsel_m = 1'b0; htrans = T_IDLE; haddr = 32'h0;
        hwrite = 1'b0; hsize = 3'd2; hburst = 3'd0; hprot = 4'd0; hwdata = 32'h0;
        #1;
        chk("rst_hreadyo0", 32'(hreadyo0), 32'h1);
        chk("rst_hresp0",   32'(hresp0),   32'h0);
        chk("rst_hrdata0",  hrdata0,       32'h0);
        chk("rst_hreadyo3", 32'(hreadyo3), 32'h1);
        chk("rst_hresp3",   32'(hresp3),   32'h0);
        chk("rst_hrdata3",  hrdata3,       32'h0);
        @(posedge hclk); #1 hreset = 1'b0;

        for (int k = 0; k < 17; k++) q.push_back(vec[k]);
        run_seq(q);

        dsel = 1'b1;
        q = {};
        q.push_back(mk(1, T_NSEQ, 1, 3'd2, 32'h40, 32'hA5A55A5A, 1, R_OK,  32'h0));
        q.push_back(mk(1, T_NSEQ, 0, 3'd2, 32'h40, 32'h0,        1, R_OK,  32'hA5A55A5A));
        q.push_back(mk(1, T_NSEQ, 1, 3'd2, 32'h42, 32'hFFFFFFFF, 1, R_ERR, 32'h0));
        q.push_back(mk(1, T_NSEQ, 0, 3'd2, 32'h40, 32'h0,        1, R_OK,  32'hA5A55A5A));
        q.push_back(mk(1, T_NSEQ, 1, 3'd2, 32'h20, 32'h12345678, 1, R_OK,  32'h0));
        run_seq(q);

        // Reset in the middle of a pending write's wait states.
        hsel_m = 1'b1; htrans = T_NSEQ; haddr = 32'h20; hwrite = 1'b1; hsize = 3'd2;
        @(posedge hclk); #1;
        hsel_m = 1'b0; htrans = T_IDLE; hwdata = 32'hFFFFFFFF;
        @(negedge hclk);
        chk("midwait_hreadyo", 32'(rdy_m), 32'h0);
        #2 hreset = 1'b1;
        #1;
        chk("async_rst_hreadyo", 32'(rdy_m), 32'h1);
        chk("async_rst_hresp",   32'(rsp_m), 32'h0);
        chk("async_rst_hrdata",  rd_m,       32'h0);
        @(posedge hclk); #1 hreset = 1'b0;
        m_clear();
        q = {};
        q.push_back(mk(1, T_NSEQ, 0, 3'd2, 32'h20, 32'h0, 1, R_OK, 32'h0));
        q.push_back(mk(1, T_NSEQ, 0, 3'd2, 32'h40, 32'h0, 1, R_OK, 32'h0));
        run_seq(q);

        rand_run(300);
        dsel = 1'b0;
        rand_run(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ahb2_slv_regmem.md
# ahb2_slv_regmem

AHB2 slave responder backed by a resettable word-organised register memory, with programmable wait states and two-cycle ERROR responses. It sits on the slave side of the AHB2 slave interface signal set (hsel / hreadyi in, hreadyo / hresp / hrdata out), behind the bus decoder and read-data/ready multiplexor. It is the responder counterpart to the bus masters and bus-functional models driving that interface, and serves as both an on-chip scratch memory and a verification target.

## Interface
- DEPTH_LOG2, 6, log2 of memory depth in 32-bit words (64 words).
- WAIT_STATES, 1, hreadyo-low cycles inserted before each OKAY data phase completes; legal range 0..15.
- hclk  input  1  bus clock; all state changes on rising edge.
- hreset  input  1  asynchronous, active-high reset.
- hsel  input  1  slave select from decoder.
- haddr  input  32  byte address, address phase.
- htrans  input  2  IDLE/BUSY/NONSEQ/SEQ.
- hwrite  input  1  1 = write.
- hsize  input  3  transfer size.
- hburst  input  3  burst type; ignored (every beat carries its own address).
- hprot  input  4  protection; ignored.
- hwdata  input  32  write data, data phase.
- hreadyi  input  1  bus-level HREADY (previous transfer done).
- hrdata  output  32  read data.
- hreadyo  output  1  this slave's ready.
- hresp  output  2  OKAY or ERROR only; RETRY/SPLIT never driven.

## Operation
- Accept: a transfer is accepted at an edge where hsel & hreadyi & htrans[1]. On acceptance, capture haddr, hwrite and hsize, and evaluate the error check. IDLE/BUSY, or hsel low, leave the state unchanged.
- Error check: flag the transfer if hsize > 3'b010, if haddr[31:DEPTH_LOG2+2] != 0, or if the address is misaligned (halfword with haddr[0]=1; word with haddr[1:0]!=0).
- States: IDLE, WAIT, DONE, ERR1, ERR2.
  - IDLE: hreadyo=1, hresp=OKAY. Accepted with error → ERR1; accepted clean with WAIT_STATES=0 → DONE; accepted clean otherwise → WAIT with cnt=WAIT_STATES-1.
  - WAIT: hreadyo=0, OKAY. cnt=0 → DONE, else cnt decrements.
  - DONE: hreadyo=1, OKAY. A write commits on this cycle's closing edge. A new acceptance on the same edge follows the IDLE rules; no acceptance → IDLE.
  - ERR1: hreadyo=0, hresp=ERROR → ERR2.
  - ERR2: hreadyo=1, hresp=ERROR. Acceptance follows the IDLE rules, else → IDLE.
- Write: the word at index addr_q[DEPTH_LOG2+1:2] updates only the byte lanes selected by little-endian size/offset. Byte: lane addr_q[1:0]. Halfword: lanes {addr_q[1],0} and {addr_q[1],1}. Word: all lanes. Erroring transfers never write.
- Read: in DONE with hwrite_q=0, hrdata = full 32-bit stored word (the master selects lanes). At all other times hrdata = 0.
- A write committing on the same edge that accepts a read of the same word makes the read return the new data.

## Timing
- Reset (asynchronous): state=IDLE, hreadyo=1, hresp=OKAY, hrdata=0, cnt=0, captured registers 0, all memory words 0.
- Reset asserted mid-transfer: the transfer is aborted immediately and a pending write is discarded.
- OKAY latency: the data phase lasts WAIT_STATES+1 cycles after the accepting edge. Back-to-back transfers complete every WAIT_STATES+1 cycles.
- ERROR: always exactly 2 data-phase cycles, independent of WAIT_STATES.
- hreadyo never goes low while the slave is not in a data phase.

## Test plan
- Reset: assert hreset mid-WAIT → outputs return to 1/OKAY/0 asynchronously. Read any word → 0x00000000.
- WAIT_STATES=0: NONSEQ word write 0x0000_0010 ← 0xDEADBEEF, then a back-to-back read of the same address → one cycle each; hrdata=0xDEADBEEF on the read's data cycle.
- WAIT_STATES=3: word read → 3 cycles hreadyo=0, then 1 cycle hreadyo=1 with data. The next NONSEQ address is held on the bus and accepted only on the ready edge.
- Byte/halfword: word 0x0 = 0x11223344; byte write addr 0x2 ← 0xAA in lane 2; halfword write 0x0 ← 0xBEEF → read = 0x11AABEEF.
- Errors: word at 0x0000_0102, hsize=3'b011, or addr 0x0000_0100 with DEPTH_LOG2=6 → ERROR/hreadyo=0, then ERROR/hreadyo=1; memory unchanged. A NONSEQ accepted in ERR2 completes normally.
- IDLE/BUSY with hsel=1, and NONSEQ with hsel=0 → hreadyo stays 1, OKAY, no memory change.
